regfile_dumper: RTL and testbench

Sequential read-side companion to the 16 x 8 register file: on a start pulse it walks a contiguous, wrap-around range of register addresses through one regfile read port. It streams each register's contents out as an address-tagged byte over a valid/ready handshake. It sits beside the processor's register file and feeds the debug/trace path; it never writes the register file.

---
 rtl/regfile_dumper.sv | 139 +++++++++++++
 tb/tb_regfile_dumper.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dumper.sv
// regfile_dumper: walks a wrap-around register address range through one
// regfile read port and streams each register as an address-tagged beat.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               dump request, sampled only while idle
//   start_addr          first register of the range (captured with start)
//   end_addr            last register of the range, inclusive
//   rf_read_addr        regfile read address, always driven from cur
//   rf_read_data        combinational regfile read data
//   out_valid/out_ready valid/ready handshake of the output stream
//   out_addr/out_data   register index and contents of the current beat
//   out_last            current beat is the final register of the range
//   busy                high whenever the block is not idle
//   done                one-cycle pulse after the last beat is accepted
module regfile_dumper #(
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter int DATA_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] rf_read_addr,
   input  logic [DATA_W-1:0] rf_read_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   // cur walks the range; last is the inclusive end captured at start
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] last_q, last_d;

   // registered beat; held stable for as long as the consumer stalls
   logic              vld_q, vld_d;
   logic [ADDR_W-1:0] baddr_q, baddr_d;
   logic [DATA_W-1:0] bdata_q, bdata_d;
   logic              blast_q, blast_d;

   logic [ADDR_W-1:0] cur_inc;
   logic              xfer;

   // modulo form keeps the walk correct even if the address
   // space is wider than the register count
   assign cur_inc = ADDR_W'((32'(cur_q) + 32'd1) % NUM_REGS);
   assign xfer    = vld_q & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         last_q  <= '0;
         vld_q   <= 1'b0;
         baddr_q <= '0;
         bdata_q <= '0;
         blast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         vld_q   <= vld_d;
         baddr_q <= baddr_d;
         bdata_q <= bdata_d;
         blast_q <= blast_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      vld_d   = vld_q;
      baddr_d = baddr_q;
      bdata_d = bdata_q;
      blast_d = blast_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_d   = start_addr;
               last_d  = end_addr;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // snapshot this register now; later regfile
            // writes to it do not affect the beat
            bdata_d = rf_read_data;
            baddr_d = cur_q;
            blast_d = (cur_q == last_q);
            vld_d   = 1'b1;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (xfer) begin
               vld_d = 1'b0;
               if (blast_q) begin
                  state_d = S_DONE;
               end else begin
                  cur_d   = cur_inc;
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // read address comes straight from a register, never from
   // combinational next-state logic
   assign rf_read_addr = cur_q;
   assign out_valid    = vld_q;
   assign out_addr     = baddr_q;
   assign out_data     = bdata_q;
   assign out_last     = blast_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper: table-driven and randomized checks of regfile_dumper
// against a queue-based model of the address walk.
module tb_regfile_dumper;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [3:0] start_addr = '0;
   logic [3:0] end_addr = '0;
   logic [3:0] rf_read_addr;
   logic [7:0] rf_read_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_addr;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       done;

   logic [7:0] rf [16];

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   assign rf_read_data = rf[rf_read_addr];

   regfile_dumper #(
      .NUM_REGS(16),
      .ADDR_W  (4),
      .DATA_W  (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .start_addr  (start_addr),
      .end_addr    (end_addr),
      .rf_read_addr(rf_read_addr),
      .rf_read_data(rf_read_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done)
   );

   typedef struct {
      logic [3:0] sa;
      logic [3:0] ea;
      int         mode;   // 0 ready=1, 1 random ready, 2 stall beat 2, 3 start while busy
      int         beats;
      logic [3:0] last;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_rra"}, 32'(rf_read_addr), 32'd0);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_addr"}, 32'(out_addr), 32'd0);
      chk({tag, "_data"}, 32'(out_data), 32'd0);
      chk({tag, "_last"}, 32'(out_last), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
   endtask

   task automatic preload();
      for (int i = 0; i < 16; i++) rf[i] = 8'hA0 + 8'(i);
   endtask

   // runs one dump; all driving and sampling happens at negedge
   task automatic run_dump(input logic [3:0] sa, input logic [3:0] ea,
                           input int mode, input int exp_beats,
                           input logic [3:0] exp_last);
      int q[$];
      int len;
      int done_k;
      int beats;
      int hold;
      int a;
      logic [3:0] h_addr, h_rra, last_addr;
      logic [7:0] h_data;
      logic       h_last;
      len = (((int'(ea) - int'(sa)) % 16) + 16) % 16 + 1;
      for (int i = 0; i < len; i++) q.push_back((int'(sa) + i) % 16);
      @(negedge clk);
      start = 1'b1;
      start_addr = sa;
      end_addr = ea;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start_addr = 4'($urandom);
      end_addr = 4'($urandom);
      done_k = -1;
      beats = 0;
      hold = 0;
      last_addr = '0;
      h_addr = '0; h_rra = '0; h_data = '0; h_last = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (done) begin
            done_k = k;
            break;
         end
         out_ready = 1'b1;
         if (mode == 1) begin
            out_ready = 1'($urandom_range(0, 1));
         end else if (mode == 2) begin
            if (beats == 1 && out_valid && hold < 4) begin
               if (hold == 0) begin
                  h_addr = out_addr; h_data = out_data;
                  h_last = out_last; h_rra = rf_read_addr;
               end else begin
                  chk("stall_valid", 32'(out_valid), 32'd1);
                  chk("stall_addr", 32'(out_addr), 32'(h_addr));
                  chk("stall_data", 32'(out_data), 32'(h_data));
                  chk("stall_last", 32'(out_last), 32'(h_last));
                  chk("stall_rra", 32'(rf_read_addr), 32'(h_rra));
               end
               out_ready = (hold == 3);
               hold++;
            end
         end else if (mode == 3) begin
            start = (k == 5 || k == 6);
            start_addr = sa + 4'd3;
            end_addr = sa + 4'd4;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("extra_beat", 32'(beats + 1), 32'(len));
            end else begin
               a = q.pop_front();
               chk("beat_addr", 32'(out_addr), 32'(a));
               chk("beat_data", 32'(out_data), 32'(rf[a]));
               chk("beat_last", 32'(out_last), 32'(q.size() == 0));
               chk("beat_busy", 32'(busy), 32'd1);
               last_addr = out_addr;
            end
            beats++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("done_seen", 32'(done_k >= 0), 32'd1);
      chk("beat_count", 32'(beats), 32'(exp_beats));
      chk("last_addr", 32'(last_addr), 32'(exp_last));
      if (mode != 1)
         chk("done_cycle", 32'(done_k),
             32'(mode == 2 ? 2 * exp_beats + 3 : 2 * exp_beats));
      // start in the DONE cycle must be dropped
      if (mode == 3) begin
         start = 1'b1;
         start_addr = 4'd0;
         end_addr = 4'd0;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse_end", 32'(done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      if (mode == 3) begin
         repeat (4) @(negedge clk);
         chk("no_requeue", 32'(busy | out_valid), 32'd0);
      end
   endtask

   initial begin
      logic [3:0] rsa, rea;
      int cnt;
      int seen;
      preload();
      #2 reset = 1'b1;
      #1 all_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      all_zero("post_reset");

      vecs[0] = '{4'd0,  4'd15, 0, 16, 4'd15};
      vecs[1] = '{4'd5,  4'd5,  0, 1,  4'd5};
      vecs[2] = '{4'd14, 4'd1,  0, 4,  4'd1};
      vecs[3] = '{4'd3,  4'd2,  0, 16, 4'd2};
      vecs[4] = '{4'd0,  4'd15, 2, 16, 4'd15};
      vecs[5] = '{4'd2,  4'd9,  3, 8,  4'd9};
      for (int v = 0; v < 6; v++) begin
         preload();
         rf[5] = 8'h3C;
         run_dump(vecs[v].sa, vecs[v].ea, vecs[v].mode,
                  vecs[v].beats, vecs[v].last);
      end

      // reset during beat 3 of a full dump
      preload();
      @(negedge clk);
      start = 1'b1; start_addr = 4'd0; end_addr = 4'd15;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      for (int k = 0; k < 200; k++) begin
         if (cnt == 2 && out_valid) break;
         if (out_valid && out_ready) cnt++;
         @(negedge clk);
      end
      chk("reach_beat3", 32'(out_valid), 32'd1);
      #2 reset = 1'b1;
      #1 all_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || out_valid || busy) seen = 1;
      end
      chk("post_abort_quiet", 32'(seen), 32'd0);
      run_dump(4'd0, 4'd15, 0, 16, 4'd15);

      // randomized ranges, contents and backpressure
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
         rsa = 4'($urandom);
         rea = 4'($urandom);
         run_dump(rsa, rea, 1, int'(4'(rea - rsa)) + 1, rea);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
